// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared constants and loader state encoding for the accelerator input buffer
package acc_pkg;

    localparam int ACC_BANKS      = 16;
    localparam int ACC_DATA_W     = 64;
    localparam int ACC_ADDR_W     = 14;
    localparam int ACC_BANK_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } acc_ld_state_t;

endpackage

// File: rtl/acc_din_bank_wr.sv
// rtl/acc_din_bank_wr.sv - port-A write fan-out to the 16 input BRAM banks
//
// Ports:
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_wr_vld                 accepted beat this cycle
//   i_wr_bank                target bank index
//   i_wr_addr, i_wr_data     word address and data for that bank
//   o_ena, o_wea             registered one-hot enable / write enable per bank
//   o_addra, o_dina          registered address / data per bank
module acc_din_bank_wr
    import acc_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_wr_vld,
    input  logic [ACC_BANK_IDX_W-1:0] i_wr_bank,
    input  logic [ACC_ADDR_W-1:0]     i_wr_addr,
    input  logic [ACC_DATA_W-1:0]     i_wr_data,
    output logic                      o_ena   [ACC_BANKS-1:0],
    output logic                      o_wea   [ACC_BANKS-1:0],
    output logic [ACC_ADDR_W-1:0]     o_addra [ACC_BANKS-1:0],
    output logic [ACC_DATA_W-1:0]     o_dina  [ACC_BANKS-1:0]
);

    logic                  r_en   [ACC_BANKS-1:0];
    logic [ACC_ADDR_W-1:0] r_addr [ACC_BANKS-1:0];
    logic [ACC_DATA_W-1:0] r_din  [ACC_BANKS-1:0];

    // Only the selected bank loads addr/din; the others keep their last
    // values so idle banks see no toggling on the address/data pins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int b = 0; b < ACC_BANKS; b++) begin
                r_en[b]   <= 1'b0;
                r_addr[b] <= '0;
                r_din[b]  <= '0;
            end
        end else begin
            for (int b = 0; b < ACC_BANKS; b++) begin
                r_en[b] <= i_wr_vld && (i_wr_bank == ACC_BANK_IDX_W'(b));
                if (i_wr_vld && (i_wr_bank == ACC_BANK_IDX_W'(b))) begin
                    r_addr[b] <= i_wr_addr;
                    r_din[b]  <= i_wr_data;
                end
            end
        end
    end

    assign o_ena   = r_en;
    assign o_wea   = r_en;
    assign o_addra = r_addr;
    assign o_dina  = r_din;

endmodule

// File: rtl/acc_din_bram_loader.sv
// rtl/acc_din_bram_loader.sv - fills the 16 input BRAM banks from a stream and hands off to the consumer
//
// Ports:
//   i_clk, i_rst                      clock, asynchronous active-high reset
//   i_load_start                      pulse: begin a load (IDLE only)
//   i_stage_done                      pulse: consumer finished with the banks (RUN only)
//   i_s_axis_tdata/tvalid/tlast       input beat stream
//   o_s_axis_tready                   high while loading
//   o_in_bram_ena/wea/addra/dina      port-A write interface, one entry per bank
//   o_stage_start                     banks hold a complete stage
//   o_busy                            not idle
//   o_err_len                         pulse: tlast did not coincide with the final beat
module acc_din_bram_loader
    import acc_pkg::*;
#(
    parameter int DATA_NUM = 768,
    parameter int BANKS    = 16,
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_start,
    input  logic              i_stage_done,
    input  logic [DATA_W-1:0] i_s_axis_tdata,
    input  logic              i_s_axis_tvalid,
    input  logic              i_s_axis_tlast,
    output logic              o_s_axis_tready,
    output logic              o_in_bram_ena   [BANKS-1:0],
    output logic              o_in_bram_wea   [BANKS-1:0],
    output logic [ADDR_W-1:0] o_in_bram_addra [BANKS-1:0],
    output logic [DATA_W-1:0] o_in_bram_dina  [BANKS-1:0],
    output logic              o_stage_start,
    output logic              o_busy,
    output logic              o_err_len
);

    // BANKS*DATA_NUM must not exceed 2^ADDR_W so the beat counter never wraps.
    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(BANKS * DATA_NUM - 1);

    acc_ld_state_t     r_state;
    logic [ADDR_W-1:0] r_beat_cnt;
    logic              r_stage_start;
    logic              r_err_len;

    logic              w_hs;
    logic              w_last_beat;

    assign o_s_axis_tready = (r_state == LOAD);
    assign o_busy          = (r_state != IDLE);
    assign o_stage_start   = r_stage_start;
    assign o_err_len       = r_err_len;

    assign w_hs        = i_s_axis_tvalid & o_s_axis_tready;
    assign w_last_beat = (r_beat_cnt == LAST_BEAT);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_beat_cnt    <= '0;
            r_stage_start <= 1'b0;
            r_err_len     <= 1'b0;
        end else begin
            r_err_len     <= 1'b0;
            r_stage_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_load_start) begin
                        r_beat_cnt <= '0;
                        r_state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_hs) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (w_last_beat) begin
                            r_state   <= RUN;
                            r_err_len <= ~i_s_axis_tlast;
                        end else if (i_s_axis_tlast) begin
                            r_state   <= IDLE;
                            r_err_len <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // stage_start trails entry into RUN by one cycle so the
                    // final registered write has landed before the consumer reads.
                    if (i_stage_done) begin
                        r_state <= IDLE;
                    end else begin
                        r_stage_start <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    acc_din_bank_wr u_bank_wr (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_vld  (w_hs),
        .i_wr_bank (r_beat_cnt[ACC_BANK_IDX_W-1:0]),
        .i_wr_addr (r_beat_cnt >> ACC_BANK_IDX_W),
        .i_wr_data (i_s_axis_tdata),
        .o_ena     (o_in_bram_ena),
        .o_wea     (o_in_bram_wea),
        .o_addra   (o_in_bram_addra),
        .o_dina    (o_in_bram_dina)
    );

endmodule

// File: tb/tb_acc_din_bram_loader.sv
// tb/tb_acc_din_bram_loader.sv - self-checking bench for acc_din_bram_loader
module tb_acc_din_bram_loader;

    localparam int DN     = 4;
    localparam int NB     = 16;
    localparam int NBEATS = NB * DN;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        stage_done = 1'b0;
    logic [63:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic        tready, ss, busy, err;
    logic        ena   [NB-1:0];
    logic        wea   [NB-1:0];
    logic [13:0] addra [NB-1:0];
    logic [63:0] dina  [NB-1:0];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    acc_din_bram_loader #(.DATA_NUM(DN)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_load_start    (load_start),
        .i_stage_done    (stage_done),
        .i_s_axis_tdata  (tdata),
        .i_s_axis_tvalid (tvalid),
        .i_s_axis_tlast  (tlast),
        .o_s_axis_tready (tready),
        .o_in_bram_ena   (ena),
        .o_in_bram_wea   (wea),
        .o_in_bram_addra (addra),
        .o_in_bram_dina  (dina),
        .o_stage_start   (ss),
        .o_busy          (busy),
        .o_err_len       (err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 empty, 1 filling, 2 full; k = beats accepted;
    // age = cycles spent full. Writes land one cycle after acceptance.
    int          m_phase = 0;
    int          m_k     = 0;
    int          m_age   = 0;
    logic        e_wvld  = 1'b0;
    int          e_wbank = 0;
    logic        e_err   = 1'b0;
    logic [13:0] e_addr [NB-1:0];
    logic [63:0] e_din  [NB-1:0];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_k     <= 0;
            m_age   <= 0;
            e_wvld  <= 1'b0;
            e_err   <= 1'b0;
            for (int b = 0; b < NB; b++) begin
                e_addr[b] <= '0;
                e_din[b]  <= '0;
            end
        end else begin
            e_wvld <= 1'b0;
            e_err  <= 1'b0;
            if (m_phase == 0) begin
                if (load_start) begin
                    m_phase <= 1;
                    m_k     <= 0;
                end
            end else if (m_phase == 1) begin
                if (tvalid) begin
                    e_wvld              <= 1'b1;
                    e_wbank             <= m_k % NB;
                    e_addr[m_k % NB]    <= 14'(m_k / NB);
                    e_din[m_k % NB]     <= tdata;
                    e_err               <= (tlast != (m_k == NBEATS - 1));
                    m_k                 <= m_k + 1;
                    if (m_k == NBEATS - 1) begin
                        m_phase <= 2;
                        m_age   <= 0;
                    end else if (tlast) begin
                        m_phase <= 0;
                    end
                end
            end else begin
                if (stage_done) m_phase <= 0;
                else m_age <= m_age + 1;
            end
        end
    end

    logic [15:0] act_ena, act_wea, exp_ena;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tready", tready, m_phase == 1);
            chk("busy", busy, m_phase != 0);
            chk("stage_start", ss, (m_phase == 2) && (m_age >= 1));
            chk("err_len", err, e_err);
            for (int b = 0; b < NB; b++) begin
                act_ena[b] = ena[b];
                act_wea[b] = wea[b];
            end
            exp_ena = e_wvld ? (16'd1 << e_wbank) : 16'd0;
            chk("ena_vec", act_ena, exp_ena);
            chk("wea_vec", act_wea, exp_ena);
            for (int b = 0; b < NB; b++) begin
                chk($sformatf("addra[%0d]", b), addra[b], e_addr[b]);
                chk($sformatf("dina[%0d]", b), dina[b], e_din[b]);
            end
        end
    end

    logic [63:0] shadow [NB-1:0][DN-1:0];
    int          err_cnt = 0;

    always @(negedge clk) begin
        for (int b = 0; b < NB; b++)
            if (ena[b] === 1'b1 && wea[b] === 1'b1) shadow[b][addra[b][1:0]] <= dina[b];
        if (err === 1'b1) err_cnt <= err_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // gap_mode: 0 back-to-back, 1 alternating valid, 2 random gaps with stray load_start
    task automatic run_load(input int last_k, input int tlast_at, input int gap_mode,
                            input bit rand_data, input bit chk_first);
        load_start = 1'b1;
        tick;
        load_start = 1'b0;
        for (int k = 0; k <= last_k; k++) begin
            if (gap_mode == 1 && k > 0) begin
                tvalid = 1'b0;
                tdata  = {$urandom, $urandom};
                tick;
            end else if (gap_mode == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    tvalid     = 1'b0;
                    tdata      = {$urandom, $urandom};
                    tlast      = 1'($urandom_range(0, 1));
                    load_start = 1'($urandom_range(0, 1));
                    tick;
                end
                load_start = 1'b0;
            end
            tvalid = 1'b1;
            tdata  = rand_data ? {$urandom, $urandom} : 64'(k);
            tlast  = (k == tlast_at);
            tick;
            if (k == 0 && chk_first) begin
                chk("first_ena0", ena[0], 1'b1);
                chk("first_addr0", addra[0], 14'd0);
                chk("first_din0", dina[0], 64'd0);
            end
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic check_shadow_k(input string tag);
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < DN; a++)
                chk($sformatf("%s_bank%0d_a%0d", tag, b, a), shadow[b][a], 64'(16 * a + b));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_tready"}, tready, 1'b0);
        chk({tag, "_ss"}, ss, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        for (int b = 0; b < NB; b++) begin
            chk($sformatf("%s_ena%0d", tag, b), ena[b] | wea[b], 1'b0);
            chk($sformatf("%s_addr%0d", tag, b), addra[b], 14'd0);
            chk($sformatf("%s_din%0d", tag, b), dina[b], 64'd0);
        end
    endtask

    task automatic release_stage;
        stage_done = 1'b1;
        tick;
        stage_done = 1'b0;
        chk("done_ss", ss, 1'b0);
        chk("done_busy", busy, 1'b0);
    endtask

    int err_base;
    int full;

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) tick;
        check_reset_vals("reset");
        rst    = 1'b0;
        chk_en = 1'b1;
        tick;

        // nominal load
        err_base = err_cnt;
        run_load(NBEATS - 1, NBEATS - 1, 0, 1'b0, 1'b0);
        chk("nom_n1_ss", ss, 1'b0);
        chk("nom_n1_tready", tready, 1'b0);
        tick;
        chk("nom_n2_ss", ss, 1'b1);
        chk("nom_err_cnt", err_cnt - err_base, 0);
        check_shadow_k("nom");
        release_stage;

        // stall pattern
        err_base = err_cnt;
        run_load(NBEATS - 1, NBEATS - 1, 1, 1'b0, 1'b0);
        tick;
        chk("stall_ss", ss, 1'b1);
        chk("stall_err_cnt", err_cnt - err_base, 0);
        check_shadow_k("stall");
        release_stage;

        // early tlast on beat 20
        err_base = err_cnt;
        run_load(20, 20, 0, 1'b0, 1'b0);
        tick;
        chk("early_err_cnt", err_cnt - err_base, 1);
        chk("early_busy", busy, 1'b0);
        repeat (3) tick;
        chk("early_ss", ss, 1'b0);
        run_load(NBEATS - 1, NBEATS - 1, 0, 1'b0, 1'b1);
        tick;
        chk("reload_ss", ss, 1'b1);
        check_shadow_k("reload");
        release_stage;

        // missing tlast
        err_base = err_cnt;
        run_load(NBEATS - 1, -1, 0, 1'b0, 1'b0);
        tick;
        chk("miss_ss", ss, 1'b1);
        chk("miss_err_cnt", err_cnt - err_base, 1);

        // handoff: stage_done and load_start together in RUN
        stage_done = 1'b1;
        load_start = 1'b1;
        tick;
        stage_done = 1'b0;
        load_start = 1'b0;
        chk("hand_ss", ss, 1'b0);
        chk("hand_busy", busy, 1'b0);
        chk("hand_tready", tready, 1'b0);
        tick;
        chk("hand_dropped", busy, 1'b0);
        run_load(NBEATS - 1, NBEATS - 1, 0, 1'b0, 1'b0);
        tick;
        chk("hand_next_ss", ss, 1'b1);
        release_stage;

        // reset mid-load after beat 30
        run_load(30, -1, 0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        tick;
        tick;
        rst = 1'b0;
        tick;
        run_load(NBEATS - 1, NBEATS - 1, 0, 1'b0, 1'b0);
        tick;
        chk("postrst_ss", ss, 1'b1);
        check_shadow_k("postrst");
        release_stage;

        // randomized loads
        for (int it = 0; it < 8; it++) begin
            full = ($urandom_range(0, 3) != 0);
            if (full != 0) begin
                run_load(NBEATS - 1, ($urandom_range(0, 4) == 0) ? -1 : NBEATS - 1, 2, 1'b1, 1'b0);
                repeat ($urandom_range(0, 3)) begin
                    load_start = 1'($urandom_range(0, 1));
                    tick;
                end
                load_start = 1'($urandom_range(0, 1));
                stage_done = 1'b1;
                tick;
                stage_done = 1'b0;
                load_start = 1'b0;
            end else begin
                int e;
                e = $urandom_range(0, NBEATS - 2);
                run_load(e, e, 2, 1'b1, 1'b0);
                stage_done = 1'($urandom_range(0, 1));
                tick;
                stage_done = 1'b0;
            end
            tick;
        end

        repeat (3) tick;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
